// File: rtl/wb_stream_pkg.sv
// rtl/wb_stream_pkg.sv - Wishbone cycle-type constants and writer FSM states
package wb_stream_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } wr_state_t;

endpackage

// File: rtl/wb_stream_fifo.sv
// rtl/wb_stream_fifo.sv - synchronous show-ahead FIFO with occupancy count
module wb_stream_fifo #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/wb_stream_burst_writer.sv
// rtl/wb_stream_burst_writer.sv - stream-to-Wishbone burst writer; irq enabled by WB_STREAM_BURST_WRITER_IRQ_EN
module wb_stream_burst_writer
    import wb_stream_pkg::*;
#(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [WB_DW-1:0]     stream_data_i,
    input  logic                 stream_valid_i,
    output logic                 stream_ready_o,
    input  logic [WB_AW-1:0]     start_adr_i,
    input  logic [WB_AW-1:0]     buf_words_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 irq_o,
    input  logic                 irq_clr_i,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i
);

    localparam int               CW      = FIFO_AW + 1;
    localparam logic [WB_AW-1:0] STEP    = WB_AW'(WB_DW / 8);
    localparam logic [WB_AW-1:0] MAXL_AW = WB_AW'(MAX_BURST_LEN);

    wr_state_t        state;
    wr_state_t        state_nxt;
    logic [WB_AW-1:0] adr_q;
    logic [WB_AW-1:0] remain_q;
    logic [CW-1:0]    beats_q;
    logic             err_q;

    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             unused_fifo_empty;
    logic             fifo_pop;
    logic [WB_DW-1:0] fifo_head;

    logic [CW-1:0]    burst_len;
    logic             last_beat;
    logic             accept_start;
    logic             done_evt;
    logic             bus_err;

    wb_stream_fifo #(
        .DW (WB_DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (stream_valid_i),
        .wdata (stream_data_i),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (unused_fifo_empty)
    );

    assign stream_ready_o = !fifo_full;
    assign busy_o         = (state != ST_IDLE);
    assign err_o          = err_q;
    assign wbm_adr_o      = adr_q;
    assign wbm_dat_o      = fifo_head;
    assign wbm_bte_o      = BTE_LINEAR;

    assign burst_len = (remain_q < MAXL_AW) ? remain_q[CW-1:0] : CW'(MAX_BURST_LEN);
    assign last_beat = (beats_q == CW'(1));
    // An error wins over a coincident ack so no word is consumed on a failed beat.
    assign bus_err   = (state == ST_BURST) && wbm_err_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fifo_pop     = 1'b0;
        done_evt     = 1'b0;
        accept_start = 1'b0;
        wbm_cyc_o    = 1'b0;
        wbm_stb_o    = 1'b0;
        wbm_we_o     = 1'b0;
        wbm_sel_o    = '0;
        wbm_cti_o    = CTI_CLASSIC;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    accept_start = 1'b1;
                    if (buf_words_i == '0) begin
                        done_evt = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (fifo_count >= burst_len) begin
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_sel_o = '1;
                wbm_cti_o = last_beat ? CTI_EOB : CTI_INC;
                if (wbm_err_i) begin
                    state_nxt = ST_IDLE;
                end else if (wbm_ack_i) begin
                    fifo_pop = 1'b1;
                    if (last_beat) begin
                        if (remain_q == WB_AW'(1)) begin
                            state_nxt = ST_IDLE;
                            done_evt  = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            adr_q    <= '0;
            remain_q <= '0;
            beats_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept_start) begin
                adr_q    <= start_adr_i;
                remain_q <= buf_words_i;
                err_q    <= 1'b0;
            end
            if (state == ST_WAIT && state_nxt == ST_BURST) begin
                beats_q <= burst_len;
            end
            if (bus_err) begin
                err_q <= 1'b1;
            end
            if (fifo_pop) begin
                adr_q    <= adr_q + STEP;
                remain_q <= remain_q - WB_AW'(1);
                beats_q  <= beats_q - CW'(1);
            end
        end
    end

`ifdef WB_STREAM_BURST_WRITER_IRQ_EN
    logic irq_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_q <= 1'b0;
        end else if (done_evt) begin
            irq_q <= 1'b1;
        end else if (irq_clr_i) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_irq;

    assign unused_irq = irq_clr_i ^ done_evt;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: doc/wb_stream_burst_writer.md
WB_STREAM_BURST_WRITER -- requirements
Module: wb_stream_burst_writer

Interface
REQ-001 SHALL have parameter WB_AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter WB_DW, default 32, Wishbone/stream data width.
REQ-003 SHALL have parameter FIFO_AW, default 4, log2 of the internal FIFO depth (16 words).
REQ-004 SHALL have parameter MAX_BURST_LEN, default 8, maximum beats per burst; must satisfy 1 <= MAX_BURST_LEN <= 2**FIFO_AW.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 wb_clk_i  in  1  clock; all logic on its rising edge.
REQ-007 wb_rst_i  in  1  synchronous active-high reset.
REQ-008 stream_data_i  in  WB_DW  stream word.
REQ-009 stream_valid_i  in  1  stream word valid.
REQ-010 stream_ready_o  out  1  FIFO not full; a word transfers when valid and ready are both high.
REQ-011 start_adr_i  in  WB_AW  byte address of the first word; sampled on start.
REQ-012 buf_words_i  in  WB_AW  number of words to write; sampled on start.
REQ-013 start_i  in  1  one-cycle start pulse; ignored unless idle.
REQ-014 busy_o  out  1  high from the cycle after an accepted start until completion or abort.
REQ-015 err_o  out  1  sticky; set on wbm_err_i; cleared by the next accepted start.
REQ-016 irq_o  out  1  completion interrupt (see Configuration).
REQ-017 irq_clr_i  in  1  clears irq_o.
REQ-018 wbm_adr_o WB_AW, wbm_dat_o WB_DW, wbm_sel_o WB_DW/8, wbm_we_o 1, wbm_cti_o 3, wbm_bte_o 2, wbm_cyc_o 1, wbm_stb_o 1  out  Wishbone B3 master.
REQ-019 wbm_ack_i, wbm_err_i  in  1  Wishbone slave responses.

Function
REQ-020 FSM states: IDLE, WAIT, BURST.
REQ-021 IDLE: on start_i, latch address/count and clear err_o; buf_words_i = 0 stays in IDLE and completes at once (irq event); otherwise go to WAIT.
REQ-022 WAIT: burst length L = min(MAX_BURST_LEN, remaining words); enter BURST when FIFO count >= L.
REQ-023 BURST: cyc_o = stb_o = we_o = 1, sel_o all ones, bte_o = 2'b00 (linear), dat_o = FIFO head (show-ahead, zero-latency).
REQ-024 cti_o = 3'b010 on every beat except the last beat of the burst, which carries 3'b111; L = 1 issues one beat with cti 3'b111.
REQ-025 Each wbm_ack_i pops one FIFO word, advances the address by WB_DW/8 modulo 2**WB_AW, and decrements the remaining count.
REQ-026 Last ack of a burst: drop cyc_o/stb_o for at least one cycle, then go to WAIT if words remain, else IDLE with a completion event.
REQ-027 wbm_err_i during BURST: drop cyc_o/stb_o next cycle, set err_o, pop no word, go to IDLE without a completion event; FIFO contents are retained.
REQ-028 A simultaneous wbm_ack_i and wbm_err_i counts as an error.
REQ-029 The FIFO accepts stream words in every state, including IDLE; with a simultaneous push and pop the count is unchanged.
REQ-030 stream_ready_o is low only when the FIFO holds 2**FIFO_AW words.

Reset
REQ-031 Reset: state IDLE; FIFO emptied; busy_o, err_o, irq_o, cyc_o, stb_o, we_o = 0; adr_o = 0; cti_o = 0; bte_o = 0.
REQ-032 Reset during BURST drops cyc_o on the next edge, with no further beats.

Configuration
REQ-033 With WB_STREAM_BURST_WRITER_IRQ_EN defined, irq_o is set one cycle after a completion event and stays set until irq_clr_i; if set and clear coincide, set wins.
REQ-034 Without WB_STREAM_BURST_WRITER_IRQ_EN, irq_o is tied to 0 and irq_clr_i is ignored.

Structure
REQ-035 Package wb_stream_pkg holds the CTI constants (CLASSIC 000, INC 010, EOB 111), the BTE_LINEAR constant and the FSM state enumeration.
REQ-036 Sub-module wb_stream_fifo: synchronous show-ahead FIFO with a FIFO_AW-bit address, a count output and full/empty flags.

Verification
REQ-037 start_adr 0x1000, buf_words 8, 8 stream words 0xA0..0xA7, immediate ack -> one burst at 0x1000..0x101C, cti 010 x7 then 111, busy_o falls, irq_o = 1.
REQ-038 buf_words 11, MAX_BURST_LEN 8 -> bursts of 8 then 3 beats, cyc_o low at least 1 cycle between them, last address 0x1028.
REQ-039 Stream supplies 1 word per 3 cycles, buf_words 4 -> WAIT holds cyc_o low until 4 words are in the FIFO; data order preserved.
REQ-040 wbm_err_i on beat 3 -> cyc_o low next cycle, err_o = 1, irq_o = 0, busy_o = 0; a new start clears err_o.
REQ-041 Hold stream valid high with no start, FIFO_AW 4 -> stream_ready_o falls after 16 words; a start with buf_words 1 -> single beat with cti 111, ready_o rises.
REQ-042 start_adr 0xFFFFFFFC, buf_words 2 -> second beat address 0x00000000.
